// File: rtl/pkg_axil_arb.sv
// Shared types and helpers for the AXI-Lite round-robin slave arbiter.
// Used by the top level and by the rr_pick priority search.
package pkg_axil_arb;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index width with a floor of 1, so a single-master build still has a usable index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester at or after ptr, wrapping at the top.
// ptr is expected to be below NUMBER_MASTER.
module rr_pick
  import pkg_axil_arb::*;
#(
  parameter int NUMBER_MASTER = 32,
  parameter int IDX_W         = idx_w(NUMBER_MASTER)
) (
  input  logic [NUMBER_MASTER-1:0] req,
  input  logic [IDX_W-1:0]         ptr,
  output logic [NUMBER_MASTER-1:0] pick,
  output logic [IDX_W-1:0]         pick_idx,
  output logic                     any_req
);

  int   m;
  logic found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any_req  = |req;
    found    = 1'b0;
    m        = 0;
    // Walk k steps from ptr; the explicit wrap keeps m inside the request vector.
    for (int k = 0; k < NUMBER_MASTER; k++) begin
      m = int'(ptr) + k;
      if (m >= NUMBER_MASTER) begin
        m = m - NUMBER_MASTER;
      end
      if (!found && req[m]) begin
        found    = 1'b1;
        pick[m]  = 1'b1;
        pick_idx = IDX_W'(m);
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter for one AXI-Lite slave channel path; a grant is held until the
// response handshake (done_i) so the interconnect mux only switches between transactions.
module axi_lite_rr_arbiter
  import pkg_axil_arb::*;
#(
  parameter int NUMBER_MASTER = 32,
  parameter int IDX_W         = idx_w(NUMBER_MASTER)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] req_i,
  input  logic                     done_i,
  output logic [NUMBER_MASTER-1:0] gnt_o,
  output logic [IDX_W-1:0]         gnt_idx_o,
  output logic                     gnt_valid_o,
  output logic                     dbg_state_o,
  output logic [IDX_W-1:0]         dbg_ptr_o
);

  // Handshake: req_i is a level held by the decoder while an address is pending; a grant
  // is issued only from IDLE and stays frozen (req_i ignored) until a one-cycle done_i
  // pulse, after which there is always one IDLE cycle before the next grant.

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [NUMBER_MASTER-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     valid_q, valid_d;

  logic [NUMBER_MASTER-1:0] pick;
  logic [IDX_W-1:0]         pick_idx;
  logic                     any_req;

  rr_pick #(
    .NUMBER_MASTER (NUMBER_MASTER),
    .IDX_W         (IDX_W)
  ) u_rr_pick (
    .req      (req_i),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          gnt_d   = pick;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          // Explicit wrap so ptr stays below NUMBER_MASTER for non-power-of-two counts.
          if (int'(pick_idx) == NUMBER_MASTER - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = pick_idx + IDX_W'(1);
          end
        end
      end
      BUSY: begin
        if (done_i) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter with 32 masters: reset, grant/release,
// rotation, lock, wrap, idle done and asynchronous reset.
module tb_axi_lite_rr_arbiter;

  localparam int N  = 32;
  localparam int IW = 5;

  logic          aclk;
  logic          aresetn;
  logic [N-1:0]  req_i;
  logic          done_i;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          gnt_valid_o;
  logic          dbg_state_o;
  logic [IW-1:0] dbg_ptr_o;

  int total;
  int bad;

  axi_lite_rr_arbiter #(.NUMBER_MASTER(N)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .dbg_state_o (dbg_state_o),
    .dbg_ptr_o   (dbg_ptr_o)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic apply_reset();
    aresetn = 1'b0;
    req_i   = '0;
    done_i  = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic release_grant();
    done_i = 1'b1;
    req_i  = '0;
    @(negedge aclk);
    done_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      total++;
      if (gnt_o !== '0 || gnt_idx_o !== '0 || gnt_valid_o !== 1'b0 ||
          dbg_state_o !== 1'b0 || dbg_ptr_o !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: gnt=%h idx=%0d valid=%b state=%b ptr=%0d, want all 0",
                 c, gnt_o, gnt_idx_o, gnt_valid_o, dbg_state_o, dbg_ptr_o);
      end
    end
  endtask

  task automatic test_single();
    req_i = 32'h0000_0010;
    @(negedge aclk);
    total++;
    if (gnt_o !== 32'h10 || gnt_idx_o !== 5'd4 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%h idx=%0d valid=%b, want 00000010 4 1",
               gnt_o, gnt_idx_o, gnt_valid_o);
    end
    release_grant();
    total++;
    if (gnt_o !== '0 || gnt_idx_o !== '0 || gnt_valid_o !== 1'b0 || dbg_ptr_o !== 5'd5) begin
      bad++;
      $display("FAIL single_release: gnt=%h idx=%0d valid=%b ptr=%0d, want 0 0 0 ptr 5",
               gnt_o, gnt_idx_o, gnt_valid_o, dbg_ptr_o);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_gnt;
    apply_reset();
    req_i = '1;
    for (int g = 0; g <= N; g++) begin
      @(negedge aclk);
      exp_gnt = '0;
      exp_gnt[g % N] = 1'b1;
      total++;
      if (gnt_valid_o !== 1'b1 || gnt_idx_o !== IW'(g % N) || gnt_o !== exp_gnt) begin
        bad++;
        $display("FAIL rotation_grant %0d: gnt=%h idx=%0d valid=%b, want %h %0d 1",
                 g, gnt_o, gnt_idx_o, gnt_valid_o, exp_gnt, g % N);
      end
      repeat (2) @(negedge aclk);
      done_i = 1'b1;
      @(negedge aclk);
      done_i = 1'b0;
      total++;
      if (gnt_valid_o !== 1'b0 || dbg_state_o !== 1'b0) begin
        bad++;
        $display("FAIL rotation_idle_gap %0d: valid=%b state=%b, want 0 0",
                 g, gnt_valid_o, dbg_state_o);
      end
    end
    req_i = '0;
    @(negedge aclk);
  endtask

  task automatic test_lock();
    // ptr is 1 after the rotation ended on master 0
    req_i = 32'h0000_0008;
    @(negedge aclk);
    total++;
    if (gnt_idx_o !== 5'd3 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL lock_grant: idx=%0d valid=%b, want 3 1", gnt_idx_o, gnt_valid_o);
    end
    req_i = 32'h0000_0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      total++;
      if (gnt_idx_o !== 5'd3 || gnt_o !== 32'h8 || gnt_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL lock_hold cycle %0d: gnt=%h idx=%0d valid=%b, want 00000008 3 1",
                 c, gnt_o, gnt_idx_o, gnt_valid_o);
      end
    end
    done_i = 1'b1;
    @(negedge aclk);
    done_i = 1'b0;
    @(negedge aclk);
    total++;
    if (gnt_idx_o !== 5'd0 || gnt_o !== 32'h1 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL lock_next: gnt=%h idx=%0d valid=%b, want 00000001 0 1",
               gnt_o, gnt_idx_o, gnt_valid_o);
    end
    release_grant();
  endtask

  task automatic test_wrap();
    req_i = 32'h4000_0000;
    @(negedge aclk);
    release_grant();
    total++;
    if (dbg_ptr_o !== 5'd31) begin
      bad++;
      $display("FAIL wrap_ptr: ptr=%0d, want 31", dbg_ptr_o);
    end
    req_i = 32'h0000_0006;
    @(negedge aclk);
    total++;
    if (gnt_idx_o !== 5'd1 || gnt_o !== 32'h2 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_grant: gnt=%h idx=%0d valid=%b, want 00000002 1 1",
               gnt_o, gnt_idx_o, gnt_valid_o);
    end
    release_grant();
  endtask

  task automatic test_done_idle();
    done_i = 1'b1;
    @(negedge aclk);
    done_i = 1'b0;
    @(negedge aclk);
    total++;
    if (gnt_o !== '0 || gnt_valid_o !== 1'b0 || dbg_state_o !== 1'b0 || dbg_ptr_o !== 5'd2) begin
      bad++;
      $display("FAIL done_in_idle: gnt=%h valid=%b state=%b ptr=%0d, want 0 0 0 ptr 2",
               gnt_o, gnt_valid_o, dbg_state_o, dbg_ptr_o);
    end
  endtask

  task automatic test_async_reset();
    req_i = 32'h0000_0080;
    @(negedge aclk);
    total++;
    if (gnt_idx_o !== 5'd7 || gnt_valid_o !== 1'b1 || dbg_ptr_o !== 5'd8) begin
      bad++;
      $display("FAIL areset_setup: idx=%0d valid=%b ptr=%0d, want 7 1 8",
               gnt_idx_o, gnt_valid_o, dbg_ptr_o);
    end
    #1 aresetn = 1'b0;
    #1;
    total++;
    if (gnt_o !== '0 || gnt_idx_o !== '0 || gnt_valid_o !== 1'b0 || dbg_ptr_o !== '0) begin
      bad++;
      $display("FAIL areset_clear: gnt=%h idx=%0d valid=%b ptr=%0d, want all 0",
               gnt_o, gnt_idx_o, gnt_valid_o, dbg_ptr_o);
    end
    req_i = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    // from ptr 0 master 1 wins; a stale ptr of 8 would pick master 9
    req_i = 32'h0000_0202;
    @(negedge aclk);
    total++;
    if (gnt_idx_o !== 5'd1 || gnt_o !== 32'h2 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL areset_regrant: gnt=%h idx=%0d valid=%b, want 00000002 1 1",
               gnt_o, gnt_idx_o, gnt_valid_o);
    end
    release_grant();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    aresetn = 1'b0;
    req_i   = '0;
    done_i  = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_lock();
    test_wrap();
    test_done_idle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
# axi_lite_rr_arbiter

Round-robin arbiter that shares one AXI-Lite slave port of the interconnect among up to NUMBER_MASTER requesting masters. One instance sits per slave per channel direction (write path: AW/W/B; read path: AR/R). The address decoder raises a request when a master's address falls inside the slave's offset/range window. The arbiter grants one master, then locks that grant until the slave's response handshake completes, so the interconnect mux only switches between whole transactions.

## Interface
- NUMBER_MASTER, default 32: number of requesters; legal range 1..32.
- IDX_W, default $clog2(NUMBER_MASTER) with a minimum of 1: width of the grant index.
- aclk  input  1  clock; all state changes on the rising edge.
- aresetn  input  1  reset, asynchronous assert, active-low; release is synchronous to aclk.
- req_i  input  NUMBER_MASTER  per-master request from the address decoder; bit m high means master m has a pending valid address for this slave.
- done_i  input  1  single-cycle pulse on the completing response handshake: BVALID&BREADY on the write path, RVALID&RREADY on the read path.
- gnt_o  output  NUMBER_MASTER  one-hot grant; all zeros when idle.
- gnt_idx_o  output  IDX_W  binary index of the granted master; 0 when idle.
- gnt_valid_o  output  1  high while a grant is held.

## Operation
- Two-state FSM, IDLE and BUSY; reset state is IDLE.
- **IDLE**
  - If any bit of req_i is high, select the first requesting master at or after priority pointer ptr, searching upward and wrapping from NUMBER_MASTER-1 to 0.
  - Register the selection into gnt_o and gnt_idx_o, set gnt_valid_o, go to BUSY.
  - Set ptr to (selected+1) mod NUMBER_MASTER.
  - If req_i is all zeros, stay in IDLE and leave ptr unchanged.
- **BUSY**
  - Grant outputs are frozen and req_i is ignored, including deassertion of the granted master's own request.
  - On done_i, clear gnt_o, gnt_idx_o and gnt_valid_o and return to IDLE.
- done_i in IDLE is ignored: no state, output or ptr change.
- ptr is IDX_W bits and resets to 0. The wrap from NUMBER_MASTER-1 to 0 is explicit, so ptr never holds an index ≥ NUMBER_MASTER, including when NUMBER_MASTER is not a power of two.
- NUMBER_MASTER=1: ptr stays 0; behaviour reduces to request/lock/release.
- Fairness: a continuously requesting master waits at most NUMBER_MASTER-1 transactions before it is granted.

## Timing
- Reset values: gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, ptr=0, state=IDLE.
- Asserting aresetn low mid-transaction clears all outputs immediately, without waiting for a clock edge.
- All outputs are registered; there is no combinational path from any input to any output.
- Grant latency: req_i seen high in IDLE on edge t gives the grant visible after edge t, i.e. one cycle.
- Release: done_i sampled on edge t drops gnt_valid_o after edge t.
- Re-arbitration happens on the following edge, so back-to-back grants are separated by exactly one idle cycle.
- A new request arriving in the same cycle as done_i is not considered until the IDLE cycle.

## Structure
- Shared package pkg_axil_arb holds:
  - enum arb_state_t {IDLE, BUSY};
  - a function computing IDX_W with the minimum-1 clamp, reused by the mux and decoder.
- One combinational sub-module, rr_pick: inputs req and ptr; outputs a one-hot pick, its index, and an any-request flag.
- The top level holds the FSM, ptr and the output registers.

## Test plan
- Reset then idle, all req_i=0 for 10 cycles: all outputs stay 0.
- Single request, req_i=32'h0000_0010: one cycle later gnt_o=32'h10, gnt_idx_o=4, gnt_valid_o=1.
  - Pulse done_i: the grant clears the next cycle and ptr becomes 5.
- Rotation, req_i=32'hFFFF_FFFF held and done_i pulsed 3 cycles after each grant:
  - grant index sequence 0,1,2,…,31,0;
  - exactly one idle cycle between grants.
- Lock, granted to master 3, then req_i=32'h0000_0001 while done_i stays low for 20 cycles: gnt_idx_o stays 3 throughout.
  - After done_i, the next grant goes to master 0.
- Wrap and edge cases:
  - ptr=31 with req_i=32'h0000_0006 grants master 1.
  - done_i pulsed in IDLE changes nothing.
  - aresetn pulled low while BUSY clears outputs before the next clock edge, and after release the next grant starts from ptr=0.
